// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with load, enable, terminal-count and wrap flags.
// Optional Gray-coded output is built when COUNTER_GRAY_EN is defined.
module mod_updown_counter #(
  parameter int WIDTH     = 8,
  parameter int MOD_VALUE = 256,
  parameter bit SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
`ifdef COUNTER_GRAY_EN
  output logic [WIDTH-1:0] gray,
`endif
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MOD_VALUE - 1);

  generate
    if (MOD_VALUE < 2 || longint'(MOD_VALUE) > (64'd1 << WIDTH)) begin : g_bad_mod
      $error("mod_updown_counter: illegal MOD_VALUE");
    end
  endgenerate

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic [WIDTH-1:0] w_next;
  logic             w_wrap;
  logic             w_at_max;
  logic             w_at_min;

  assign w_at_max = (r_count == MAX);
  assign w_at_min = (r_count == '0);

  always_comb begin
    w_next = r_count;
    w_wrap = 1'b0;
    if (load) begin
      w_next = (load_val > MAX) ? MAX : load_val;
    end else if (en) begin
      if (up_dn) begin
        if (!w_at_max) begin
          w_next = r_count + 1'b1;
        end else if (!SATURATE) begin
          w_next = '0;
          w_wrap = 1'b1;
        end
      end else begin
        if (!w_at_min) begin
          w_next = r_count - 1'b1;
        end else if (!SATURATE) begin
          w_next = MAX;
          w_wrap = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_count <= w_next;
      r_wrap  <= w_wrap;
    end
  end

`ifdef COUNTER_GRAY_EN
  // Encoded from the next value so gray lines up with count every cycle.
  logic [WIDTH-1:0] r_gray;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gray <= '0;
    end else begin
      r_gray <= w_next ^ (w_next >> 1);
    end
  end

  assign gray = r_gray;
`endif

  assign count = r_count;
  assign wrap  = r_wrap;
  assign tc    = en & ((up_dn & w_at_max) | (~up_dn & w_at_min));

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench for mod_updown_counter, WIDTH=4 MOD_VALUE=10.
// Runs a wrapping instance and a saturating instance on shared inputs.
module tb_mod_updown_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [3:0] load_val;

  logic [3:0] count;
  logic       tc;
  logic       wrap;
  logic [3:0] gray;
  logic [3:0] s_count;
  logic       s_tc;
  logic       s_wrap;
  logic [3:0] s_gray;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mod_updown_counter #(.WIDTH(4), .MOD_VALUE(10), .SATURATE(1'b0)) u_wrap (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .tc       (tc),
`ifdef COUNTER_GRAY_EN
    .gray     (gray),
`endif
    .wrap     (wrap)
  );

  mod_updown_counter #(.WIDTH(4), .MOD_VALUE(10), .SATURATE(1'b1)) u_sat (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .count    (s_count),
    .tc       (s_tc),
`ifdef COUNTER_GRAY_EN
    .gray     (s_gray),
`endif
    .wrap     (s_wrap)
  );

`ifndef COUNTER_GRAY_EN
  assign gray   = 4'h0;
  assign s_gray = 4'h0;
`endif

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up_dn = 1'b1;
    load = 1'b0; load_val = 4'd0;
    #1;
    tick();
    tick();
    chk("rst_count", 8'(count), 8'd0);
    chk("rst_wrap", 8'(wrap), 8'd0);
`ifdef COUNTER_GRAY_EN
    chk("rst_gray", 8'(gray), 8'h0);
`endif

    // 1: count up through the wrap
    rst = 1'b0; en = 1'b1; up_dn = 1'b1;
    #1;
    chk("up_tc0", 8'(tc), 8'd0);
    for (int k = 1; k <= 11; k++) begin
      tick();
      chk($sformatf("up_count%0d", k), 8'(count), 8'(k % 10));
      chk($sformatf("up_wrap%0d", k), 8'(wrap), 8'(k == 10));
      chk($sformatf("up_tc%0d", k), 8'(tc), 8'(k % 10 == 9));
    end

    // 2: count down through zero
    load = 1'b1; load_val = 4'd0;
    tick();
    chk("ld0_count", 8'(count), 8'd0);
    load = 1'b0; up_dn = 1'b0;
    #1;
    chk("dn_tc_at0", 8'(tc), 8'd1);
    tick();
    chk("dn_count9", 8'(count), 8'd9);
    chk("dn_wrap9", 8'(wrap), 8'd1);
    chk("dn_tc9", 8'(tc), 8'd0);
`ifdef COUNTER_GRAY_EN
    chk("gray9", 8'(gray), 8'b1101);
`endif
    tick();
    chk("dn_count8", 8'(count), 8'd8);
    chk("dn_wrap8", 8'(wrap), 8'd0);
    tick();
    chk("dn_count7", 8'(count), 8'd7);

    // 3: load, clamp, load beats a wrapping count
    load = 1'b1; load_val = 4'd3;
    tick();
    chk("ld3", 8'(count), 8'd3);
    load_val = 4'd7; up_dn = 1'b1;
    tick();
    chk("ld7", 8'(count), 8'd7);
    load_val = 4'd12;
    tick();
    chk("ld12_clamp", 8'(count), 8'd9);
    chk("ld12_wrap", 8'(wrap), 8'd0);
    chk("ld_tc_ungated", 8'(tc), 8'd1);
    tick();
    chk("ld_at9_count", 8'(count), 8'd9);
    chk("ld_at9_wrap", 8'(wrap), 8'd0);
`ifdef COUNTER_GRAY_EN
    chk("gray_ld9", 8'(gray), 8'b1101);
`endif

    // 4: saturating instance holds at the top
    load = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("sat_count%0d", k), 8'(s_count), 8'd9);
      chk($sformatf("sat_wrap%0d", k), 8'(s_wrap), 8'd0);
      chk($sformatf("sat_tc%0d", k), 8'(s_tc), 8'd1);
    end
    chk("wrap_after3", 8'(count), 8'd2);
    up_dn = 1'b0;
    tick();
    chk("sat_dn8", 8'(s_count), 8'd8);
    chk("wrap_dn1", 8'(count), 8'd1);
    load = 1'b1; load_val = 4'd0;
    tick();
    load = 1'b0;
    #1;
    chk("sat_tc_at0", 8'(s_tc), 8'd1);
    tick();
    chk("sat_hold0", 8'(s_count), 8'd0);
    chk("sat_wrap0", 8'(s_wrap), 8'd0);
    chk("wrap_dn_to9", 8'(count), 8'd9);
    chk("wrap_dn_flag", 8'(wrap), 8'd1);

    // 5: hold with en low, then reset beats load
    load = 1'b1; load_val = 4'd5; en = 1'b1;
    tick();
    chk("ld5", 8'(count), 8'd5);
    chk("ld5_wrap", 8'(wrap), 8'd0);
`ifdef COUNTER_GRAY_EN
    chk("gray5", 8'(gray), 8'b0111);
`endif
    load = 1'b0; en = 1'b0; up_dn = 1'b1;
    #1;
    chk("tc_en0", 8'(tc), 8'd0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("hold%0d", k), 8'(count), 8'd5);
    end
    rst = 1'b1; load = 1'b1; load_val = 4'd4; en = 1'b1;
    tick();
    chk("rst_wins_count", 8'(count), 8'd0);
    chk("rst_wins_wrap", 8'(wrap), 8'd0);
    chk("rst_wins_sat", 8'(s_count), 8'd0);
`ifdef COUNTER_GRAY_EN
    chk("rst_wins_gray", 8'(gray), 8'h0);
`endif
    rst = 1'b0; load = 1'b0; en = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("hold0_%0d", k), 8'(count), 8'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
